// File: rtl/d_debounce_sync.sv
// -----------------------------------------------------------------------------
// d_debounce_sync
//   Conditions a raw asynchronous level (button, switch, external strobe) into
//   a clean clock-synchronous level. A two-flop synchronizer feeds a two-state
//   qualifier that only lets dout follow the synchronized input after it has
//   differed from dout for STABLE_CYCLES+1 consecutive clocks. Shorter
//   excursions are dropped. One-cycle rise/fall pulses accompany every flip.
//
// Parameters
//   CNT_W          width of stability counter (2**CNT_W > STABLE_CYCLES)
//   STABLE_CYCLES  qualification length in clocks (>= 1)
//   RESET_LEVEL    level of dout and both sync flops while in reset
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active low
//   din   in   raw asynchronous level
//   dout  out  debounced level
//   rise  out  one-cycle pulse when dout goes 0->1
//   fall  out  one-cycle pulse when dout goes 1->0
//   busy  out  high while a candidate change is being qualified
// -----------------------------------------------------------------------------
module d_debounce_sync #(
   parameter int unsigned CNT_W         = 4,
   parameter int unsigned STABLE_CYCLES = 8,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LP_STABLE = CNT_W'(STABLE_CYCLES);

   state_t           r_state;
   logic             r_s1;
   logic             r_s2;
   logic             r_dout;
   logic             r_rise;
   logic             r_fall;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;

   // Two-flop synchronizer; r_s2 is the only view of din the qualifier uses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= RESET_LEVEL;
         r_s2 <= RESET_LEVEL;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
      end
   end

   // Qualifier FSM. The counter saturates at LP_STABLE: reaching it while the
   // input still differs commits the flip and returns to idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_dout  <= RESET_LEVEL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_s2 != r_dout) begin
                  r_state <= ST_COUNT;
                  r_cnt   <= CNT_W'(1);
                  r_busy  <= 1'b1;
               end else begin
                  r_cnt  <= '0;
                  r_busy <= 1'b0;
               end
            end
            ST_COUNT: begin
               if (r_s2 == r_dout) begin
                  // input returned before qualifying: glitch rejected
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else if (r_cnt < LP_STABLE) begin
                  r_cnt  <= r_cnt + CNT_W'(1);
                  r_busy <= 1'b1;
               end else begin
                  r_dout  <= r_s2;
                  r_rise  <= r_s2;
                  r_fall  <= !r_s2;
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dout = r_dout;
   assign rise = r_rise;
   assign fall = r_fall;
   assign busy = r_busy;

endmodule
